// File: rtl/fwd_hazard_unit_pkg.sv
// Shared opcodes, mux-select encodings and instruction decode for the forwarding/hazard unit.
package fwd_hazard_pkg;

    localparam int DEC_AW = 5;

    localparam logic [5:0] OP_LD      = 6'b010100;
    localparam logic [5:0] OP_ST      = 6'b010101;
    localparam logic [5:0] OP_JMP     = 6'b011000;
    localparam logic [3:0] OP_CJ_MSB  = 4'b0111;
    localparam logic [2:0] OP_IMM_MSB = 3'b001;
    localparam logic [2:0] OP_ALU_MSB = 3'b000;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic              rd_rs;
        logic              rd_rt;
        logic              wr_v;
        logic [DEC_AW-1:0] dst;
        logic              is_ld;
        logic              is_st;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [5:0] op;
        op = ins[31:26];
        d  = '0;
        if (op[5:3] == OP_ALU_MSB) begin
            d.rd_rs = 1'b1;
            d.rd_rt = 1'b1;
            d.wr_v  = 1'b1;
            d.dst   = ins[15:11];
        end else if (op[5:3] == OP_IMM_MSB) begin
            d.rd_rs = 1'b1;
            d.wr_v  = 1'b1;
            d.dst   = ins[20:16];
        end else if (op == OP_LD) begin
            d.rd_rs = 1'b1;
            d.wr_v  = 1'b1;
            d.dst   = ins[20:16];
            d.is_ld = 1'b1;
        end else if (op == OP_ST) begin
            d.rd_rs = 1'b1;
            d.rd_rt = 1'b1;
            d.is_st = 1'b1;
        end else if (op == OP_JMP) begin
            d = '0;
        end else if (op[5:2] == OP_CJ_MSB) begin
            d.rd_rs = 1'b1;
            d.rd_rt = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Priority match of one source register against the downstream destination history.
module fwd_sel
    import fwd_hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2
) (
    input  logic [REG_AW-1:0]                 src,
    input  logic                              rd_en,
    input  logic [FWD_DEPTH:1]                wr_v,
    input  logic [FWD_DEPTH:1]                blocked,
    input  logic [FWD_DEPTH:1][REG_AW-1:0]    dst,
    output logic [1:0]                        sel
);

    // Scan oldest to youngest so the nearest matching stage overwrites the rest.
    always_comb begin
        sel = SEL_RF;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (rd_en && (src != '0) && wr_v[k] && !blocked[k] && (dst[k] == src)) begin
                sel = 2'(k);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit between IF/ID and EX.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / fwd_cnt outputs.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int INS_W     = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ins_valid,
    input  logic [INS_W-1:0]  ins,
    output logic              stall,
    output logic [15:0]       imm,
    output logic [5:0]        op_dec,
    output logic [REG_AW-1:0] RW_dm,
    output logic [1:0]        mux_sel_A,
    output logic [1:0]        mux_sel_B,
    output logic              imm_sel,
    output logic              mem_en_ex,
    output logic              mem_rw_ex,
    output logic              mem_mux_sel_dm
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       fwd_cnt
`endif
);

    dec_t                           dec;
    logic [REG_AW-1:0]              rs;
    logic [REG_AW-1:0]              rt;
    logic                           is_imm;
    logic [FWD_DEPTH:1]             wr_v_h;
    logic [FWD_DEPTH:1]             is_ld_h;
    logic [FWD_DEPTH:1][REG_AW-1:0] dst_h;
    logic [FWD_DEPTH:1]             ld_young;
    logic [1:0]                     sel_a;
    logic [1:0]                     sel_b;
    logic                           hz;
    logic [1:0]                     hz_len;
    logic                           bubble;
    hz_state_e                      state;
    hz_state_e                      state_nx;
    logic [1:0]                     cnt;
    logic [1:0]                     cnt_nx;

    assign dec    = decode(ins[31:0]);
    assign rs     = REG_AW'(ins[25:21]);
    assign rt     = REG_AW'(ins[20:16]);
    assign is_imm = (ins[31:29] == OP_IMM_MSB);

    // Loads still inside the load-latency window cannot be forwarded yet.
    always_comb begin
        ld_young = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            ld_young[k] = is_ld_h[k] && (k <= LOAD_LAT);
        end
    end

    fwd_sel #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_sel_a (
        .src     (rs),
        .rd_en   (dec.rd_rs),
        .wr_v    (wr_v_h),
        .blocked (ld_young),
        .dst     (dst_h),
        .sel     (sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) u_sel_b (
        .src     (rt),
        .rd_en   (dec.rd_rt),
        .wr_v    (wr_v_h),
        .blocked (ld_young),
        .dst     (dst_h),
        .sel     (sel_b)
    );

    // hz_len is the total number of bubbles needed for the youngest conflicting load.
    always_comb begin
        hz     = 1'b0;
        hz_len = '0;
        for (int k = LOAD_LAT; k >= 1; k--) begin
            if (wr_v_h[k] && is_ld_h[k] &&
                ((dec.rd_rs && (rs != '0) && (dst_h[k] == rs)) ||
                 (dec.rd_rt && (rt != '0) && (dst_h[k] == rt)))) begin
                hz     = 1'b1;
                hz_len = 2'(LOAD_LAT - k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The RUN cycle that detects the hazard is the first stall cycle; cnt holds the rest.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RUN: begin
                if (hz && ins_valid && (hz_len > 2'd1)) begin
                    state_nx = ST_STALL;
                    cnt_nx   = hz_len - 2'd1;
                end
            end
            ST_STALL: begin
                if (cnt <= 2'd1) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        stall = (state == ST_STALL) || ((state == ST_RUN) && hz && ins_valid);
    end

    assign bubble = stall || !ins_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_v_h  <= '0;
            is_ld_h <= '0;
            dst_h   <= '0;
        end else begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                wr_v_h[k]  <= wr_v_h[k-1];
                is_ld_h[k] <= is_ld_h[k-1];
                dst_h[k]   <= dst_h[k-1];
            end
            wr_v_h[1]  <= !bubble && dec.wr_v;
            is_ld_h[1] <= !bubble && dec.is_ld;
            dst_h[1]   <= bubble ? '0 : REG_AW'(dec.dst);
        end
    end

    // ID -> EX register; a bubble clears every EX control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_dec    <= '0;
            imm       <= '0;
            imm_sel   <= 1'b0;
            mem_en_ex <= 1'b0;
            mem_rw_ex <= 1'b0;
            mux_sel_A <= SEL_RF;
            mux_sel_B <= SEL_RF;
        end else if (bubble) begin
            op_dec    <= '0;
            imm       <= '0;
            imm_sel   <= 1'b0;
            mem_en_ex <= 1'b0;
            mem_rw_ex <= 1'b0;
            mux_sel_A <= SEL_RF;
            mux_sel_B <= SEL_RF;
        end else begin
            op_dec    <= ins[31:26];
            imm       <= ins[15:0];
            imm_sel   <= is_imm || dec.is_ld || dec.is_st;
            mem_en_ex <= dec.is_ld || dec.is_st;
            mem_rw_ex <= dec.is_st;
            mux_sel_A <= sel_a;
            mux_sel_B <= sel_b;
        end
    end

    assign RW_dm          = wr_v_h[2] ? dst_h[2] : '0;
    assign mem_mux_sel_dm = is_ld_h[2];

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (((mux_sel_A != SEL_RF) || (mux_sel_B != SEL_RF)) && (fwd_cnt != 16'hFFFF)) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit; two configurations share one stimulus stream.
module tb_fwd_hazard_unit;

    localparam logic [5:0] T_LD = 6'b010100;
    localparam logic [5:0] T_ST = 6'b010101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ins_valid = 1'b0;
    logic [31:0] ins = '0;

    logic        stall_o [2];
    logic [15:0] imm_o   [2];
    logic [5:0]  op_o    [2];
    logic [4:0]  rw_o    [2];
    logic [1:0]  sa_o    [2];
    logic [1:0]  sb_o    [2];
    logic        isel_o  [2];
    logic        men_o   [2];
    logic        mrw_o   [2];
    logic        mmx_o   [2];
`ifdef HAZARD_STATS_EN
    logic [15:0] scnt_o  [2];
    logic [15:0] fcnt_o  [2];
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(.INS_W(32), .REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins),
        .stall(stall_o[0]), .imm(imm_o[0]), .op_dec(op_o[0]), .RW_dm(rw_o[0]),
        .mux_sel_A(sa_o[0]), .mux_sel_B(sb_o[0]), .imm_sel(isel_o[0]),
        .mem_en_ex(men_o[0]), .mem_rw_ex(mrw_o[0]), .mem_mux_sel_dm(mmx_o[0])
`ifdef HAZARD_STATS_EN
        , .stall_cnt(scnt_o[0]), .fwd_cnt(fcnt_o[0])
`endif
    );

    fwd_hazard_unit #(.INS_W(32), .REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) u1 (
        .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins(ins),
        .stall(stall_o[1]), .imm(imm_o[1]), .op_dec(op_o[1]), .RW_dm(rw_o[1]),
        .mux_sel_A(sa_o[1]), .mux_sel_B(sb_o[1]), .imm_sel(isel_o[1]),
        .mem_en_ex(men_o[1]), .mem_rw_ex(mrw_o[1]), .mem_mux_sel_dm(mmx_o[1])
`ifdef HAZARD_STATS_EN
        , .stall_cnt(scnt_o[1]), .fwd_cnt(fcnt_o[1])
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: per configuration, the list of in-flight instructions by stage.
    int DEP [2] = '{2, 3};
    int LAT [2] = '{1, 2};
    int mw  [2][4];
    int md  [2][4];
    int ml  [2][4];
    int rem [2];
    int e_op[2], e_imm[2], e_isel[2], e_men[2], e_mrw[2], e_sa[2], e_sb[2];
    int n_stall[2];
    bit last_stall;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d);
        return {op, s, t, d, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic dec(input logic [31:0] x, output bit rrs, output bit rrt, output bit wr,
                       output int dst, output bit ld, output bit st, output bit isl);
        logic [5:0] op;
        op = x[31:26];
        rrs = 0; rrt = 0; wr = 0; dst = 0; ld = 0; st = 0; isl = 0;
        if (op[5:3] == 3'b000) begin
            rrs = 1; rrt = 1; wr = 1; dst = int'(x[15:11]);
        end else if (op[5:3] == 3'b001) begin
            rrs = 1; wr = 1; dst = int'(x[20:16]); isl = 1;
        end else if (op == T_LD) begin
            rrs = 1; wr = 1; dst = int'(x[20:16]); ld = 1; isl = 1;
        end else if (op == T_ST) begin
            rrs = 1; rrt = 1; st = 1; isl = 1;
        end else if (op[5:2] == 4'b0111) begin
            rrs = 1; rrt = 1;
        end
    endtask

    function automatic int ref_sel(input int i, input int src, input bit rd);
        if (!rd || src == 0) return 0;
        for (int k = 1; k <= DEP[i]; k++)
            if (mw[i][k] != 0 && md[i][k] == src && !(ml[i][k] != 0 && k <= LAT[i])) return k;
        return 0;
    endfunction

    // Returns the number of stall cycles owed to the youngest conflicting load, or 0.
    function automatic int ref_hz(input int i, input int s, input bit rrs, input int t, input bit rrt);
        for (int k = 1; k <= LAT[i]; k++)
            if (mw[i][k] != 0 && ml[i][k] != 0 &&
                ((rrs && s != 0 && md[i][k] == s) || (rrt && t != 0 && md[i][k] == t)))
                return LAT[i] - k + 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                mw[i][k] = 0; md[i][k] = 0; ml[i][k] = 0;
            end
            rem[i] = 0;
            e_op[i] = 0; e_imm[i] = 0; e_isel[i] = 0; e_men[i] = 0;
            e_mrw[i] = 0; e_sa[i] = 0; e_sb[i] = 0;
        end
    endtask

    task automatic check_regs(input int i);
        check($sformatf("u%0d.op_dec", i),    32'(op_o[i]),   32'(e_op[i]));
        check($sformatf("u%0d.imm", i),       32'(imm_o[i]),  32'(e_imm[i]));
        check($sformatf("u%0d.imm_sel", i),   32'(isel_o[i]), 32'(e_isel[i]));
        check($sformatf("u%0d.mem_en_ex", i), 32'(men_o[i]),  32'(e_men[i]));
        check($sformatf("u%0d.mem_rw_ex", i), 32'(mrw_o[i]),  32'(e_mrw[i]));
        check($sformatf("u%0d.mux_sel_A", i), 32'(sa_o[i]),   32'(e_sa[i]));
        check($sformatf("u%0d.mux_sel_B", i), 32'(sb_o[i]),   32'(e_sb[i]));
        check($sformatf("u%0d.RW_dm", i),     32'(rw_o[i]),   32'((mw[i][2] != 0) ? md[i][2] : 0));
        check($sformatf("u%0d.mem_mux_dm", i), 32'(mmx_o[i]), 32'(ml[i][2]));
    endtask

    task automatic cycle(input logic [31:0] x, input bit v);
        bit rrs, rrt, wr, ld, st, isl;
        int dst, s, t, hl;
        int sa [2];
        int sb [2];
        bit bub [2];
        ins = x;
        ins_valid = v;
        #1;
        dec(x, rrs, rrt, wr, dst, ld, st, isl);
        s = int'(x[25:21]);
        t = int'(x[20:16]);
        for (int i = 0; i < 2; i++) begin
            bit st_e;
            hl = ref_hz(i, s, rrs, t, rrt);
            st_e = (rem[i] > 0) || (hl > 0 && v);
            sa[i] = ref_sel(i, s, rrs);
            sb[i] = ref_sel(i, t, rrt);
            check($sformatf("u%0d.stall", i), 32'(stall_o[i]), 32'(st_e));
            if (stall_o[i] === 1'b1) n_stall[i]++;
            rem[i] = (rem[i] > 0) ? rem[i] - 1 : ((hl > 0 && v) ? hl - 1 : 0);
            bub[i] = st_e || !v;
            if (i == 1) last_stall = st_e;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int k = 3; k >= 2; k--) begin
                mw[i][k] = mw[i][k-1]; md[i][k] = md[i][k-1]; ml[i][k] = ml[i][k-1];
            end
            if (bub[i]) begin
                mw[i][1] = 0; md[i][1] = 0; ml[i][1] = 0;
                e_op[i] = 0; e_imm[i] = 0; e_isel[i] = 0; e_men[i] = 0;
                e_mrw[i] = 0; e_sa[i] = 0; e_sb[i] = 0;
            end else begin
                mw[i][1] = int'(wr); md[i][1] = dst; ml[i][1] = int'(ld);
                e_op[i] = int'(x[31:26]); e_imm[i] = int'(x[15:0]); e_isel[i] = int'(isl);
                e_men[i] = int'(ld | st); e_mrw[i] = int'(st); e_sa[i] = sa[i]; e_sb[i] = sb[i];
            end
        end
        #1;
        check_regs(0);
        check_regs(1);
        @(negedge clk);
    endtask

    // ID is held upstream while the slower configuration stalls.
    task automatic issue(input logic [31:0] x, input bit v);
        int guard;
        guard = 0;
        do begin
            cycle(x, v);
            guard++;
        end while (last_stall && guard < 8);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.rst_stall", i), 32'(stall_o[i]), 32'h0);
            check_regs(i);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0, 1:    op = {3'b000, 3'($urandom)};
            2:       op = {3'b001, 3'($urandom)};
            3, 4:    op = T_LD;
            5:       op = T_ST;
            6:       op = ($urandom_range(0, 1) == 0) ? 6'b011000 : {4'b0111, 2'($urandom)};
            default: op = {1'b1, 5'($urandom)};
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                11'($urandom)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        n_stall[0] = 0;
        n_stall[1] = 0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.rst_stall", i), 32'(stall_o[i]), 32'h0);
            check_regs(i);
        end
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back ALU dependency forwards from EX.
        issue(mk_r(6'b000000, 5'd1, 5'd2, 5'd3), 1'b1);
        issue(mk_r(6'b000000, 5'd3, 5'd1, 5'd4), 1'b1);
        check("alu_fwd_A", 32'(sa_o[0]), 32'd1);
        check("alu_fwd_B", 32'(sb_o[0]), 32'd0);

        // Load-use: one stall with LOAD_LAT=1, two with LOAD_LAT=2.
        n_stall[0] = 0;
        n_stall[1] = 0;
        issue(mk_i(T_LD, 5'd1, 5'd5, 16'h0010), 1'b1);
        issue(mk_r(6'b000000, 5'd5, 5'd5, 5'd6), 1'b1);
        check("ldu_stalls_u0", 32'(n_stall[0]), 32'd1);
        check("ldu_stalls_u1", 32'(n_stall[1]), 32'd2);
        check("ldu_sel_u1", 32'(sa_o[1]), 32'd3);

        // r0 is never forwarded; ST drives memory write controls.
        issue(mk_r(6'b000000, 5'd1, 5'd2, 5'd0), 1'b1);
        issue(mk_r(6'b000000, 5'd0, 5'd0, 5'd7), 1'b1);
        check("r0_sel_A", 32'(sa_o[0]), 32'd0);
        check("r0_sel_B", 32'(sb_o[0]), 32'd0);
        issue(mk_i(T_ST, 5'd1, 5'd7, 16'h0040), 1'b1);
        check("st_mem_en", 32'(men_o[0]), 32'd1);
        check("st_mem_rw", 32'(mrw_o[0]), 32'd1);
        issue(32'hFC00_0000, 1'b1);
        check("st_rw_dm", 32'(rw_o[0]), 32'd0);

        // Nearest writer wins.
        issue(mk_r(6'b000000, 5'd1, 5'd1, 5'd2), 1'b1);
        issue(mk_r(6'b000000, 5'd3, 5'd3, 5'd2), 1'b1);
        issue(mk_r(6'b000010, 5'd2, 5'd2, 5'd8), 1'b1);
        check("near_sel_A", 32'(sa_o[0]), 32'd1);
        check("near_sel_B", 32'(sb_o[1]), 32'd1);

        for (int n = 0; n < 250; n++) issue(rnd_ins(), $urandom_range(0, 9) != 0);

        // Reset in the middle of a load-use stall.
        issue(mk_i(T_LD, 5'd1, 5'd5, 16'h0020), 1'b1);
        cycle(mk_r(6'b000000, 5'd5, 5'd5, 5'd6), 1'b1);
        apply_reset();
        issue(mk_r(6'b000000, 5'd5, 5'd5, 5'd4), 1'b1);
        check("post_rst_sel", 32'(sa_o[1]), 32'd0);

        for (int n = 0; n < 250; n++) issue(rnd_ins(), $urandom_range(0, 9) != 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
